// File: rtl/timer_alarm_pkg.sv
// Shared types and constants for the timer alarm block: FSM state encoding,
// counter widths and default blink timing.
package timer_alarm_pkg;

  localparam int PHASE_W         = 8;
  localparam int CNT_W           = 4;
  localparam int DEF_HALF_PERIOD = 4;
  localparam int DEF_BLINKS      = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALARM = 2'd1,
    ST_HOLD  = 2'd2,
    ST_COOL  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_alarm_ack_sync.sv
// Two-flop synchronizer for the asynchronous acknowledge button, followed by a
// rising-edge detector that emits exactly one pulse per press.
module ack_sync (
  input  logic clk,
  input  logic rst,
  input  logic ack_i,
  output logic pulse_o
);

  // sync_q[0]/[1] form the synchronizer; sync_q[2] remembers the previous
  // synchronized level for edge detection.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ack_i};
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/timer_alarm.sv
// Alarm sequencer: blinks alarm_led for BLINKS periods on a rising done, then
// holds steady until acknowledged. Define TIMER_ALARM_BUZZ_EN to drive buzzer.
module timer_alarm
  import timer_alarm_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int BLINKS      = DEF_BLINKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic             ack,
  output logic             alarm_led,
  output logic             buzzer,
  output logic             busy,
  output logic [CNT_W-1:0] alarm_cnt,
  output state_e           dbg_state_o
);

  localparam logic [PHASE_W-1:0] HP_LAST  = PHASE_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINKS - 1);

  state_e             state_q;
  logic               done_q;
  logic               led_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic               rise;
  logic               ack_pulse;

  ack_sync u_ack_sync (
    .clk     (clk),
    .rst     (rst),
    .ack_i   (ack),
    .pulse_o (ack_pulse)
  );

  assign rise    = done & ~done_q;
  assign phase_d = phase_q + 1'b1;
  assign cnt_d   = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      done_q <= done;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q <= ST_ALARM;
            led_q   <= 1'b1;
            cnt_q   <= '0;
            phase_q <= '0;
          end
        end
        ST_ALARM: begin
          if (ack_pulse) begin
            state_q <= ST_COOL;
            led_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= '0;
          end else if (phase_q == HP_LAST) begin
            phase_q <= '0;
            led_q   <= ~led_q;
            // A low-to-high toggle closes one full blink; the last one lands in HOLD lit.
            if (!led_q) begin
              cnt_q <= cnt_d;
              if (cnt_q == CNT_LAST) begin
                state_q <= ST_HOLD;
              end
            end
          end else begin
            phase_q <= phase_d;
          end
        end
        ST_HOLD: begin
          if (ack_pulse) begin
            state_q <= ST_COOL;
            led_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= '0;
          end
        end
        ST_COOL: begin
          if (!done) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign alarm_led   = led_q;
  assign alarm_cnt   = cnt_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

`ifdef TIMER_ALARM_BUZZ_EN
  assign buzzer = led_q & (state_q == ST_ALARM);
`else
  assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_timer_alarm.sv
// Directed bench for timer_alarm (HALF_PERIOD=4, BLINKS=3) with a time-based
// reference model compared every cycle plus literal spot checks.
module tb_timer_alarm;
  import timer_alarm_pkg::*;

  localparam int HP = 4;
  localparam int NB = 3;
`ifdef TIMER_ALARM_BUZZ_EN
  localparam logic BUZZ = 1'b1;
`else
  localparam logic BUZZ = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       done = 1'b0;
  logic       ack  = 1'b0;
  logic       alarm_led;
  logic       buzzer;
  logic       busy;
  logic [3:0] alarm_cnt;
  state_e     dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  timer_alarm #(.HALF_PERIOD(HP), .BLINKS(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .done        (done),
    .ack         (ack),
    .alarm_led   (alarm_led),
    .buzzer      (buzzer),
    .busy        (busy),
    .alarm_cnt   (alarm_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- reference model ----------------
  // Alarm outputs follow from elapsed time since the burst started.
  typedef enum int {M_IDLE, M_ALARM, M_HOLD, M_COOL} mmode_e;
  mmode_e m_mode      = M_IDLE;
  int     m_e         = 0;
  logic   m_done_prev = 1'b0;
  logic   ack_hist[$] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic   m_rise;
  logic   m_pulse;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode      = M_IDLE;
      m_e         = 0;
      m_done_prev = 1'b0;
      ack_hist    = '{1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      m_rise      = done & ~m_done_prev;
      m_done_prev = done;
      ack_hist.push_front(ack);
      // Pulse acting at this edge: ack seen high two edges ago, low three edges ago.
      m_pulse = ack_hist[2] & ~ack_hist[3];
      void'(ack_hist.pop_back());
      case (m_mode)
        M_IDLE:  if (m_rise) begin m_mode = M_ALARM; m_e = 0; end
        M_ALARM: begin
          if (m_pulse) m_mode = M_COOL;
          else begin
            m_e++;
            if (m_e == 2 * NB * HP) m_mode = M_HOLD;
          end
        end
        M_HOLD:  if (m_pulse) m_mode = M_COOL;
        M_COOL:  if (!done) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  function automatic logic exp_led();
    case (m_mode)
      M_ALARM: return ((m_e / HP) % 2) == 0;
      M_HOLD:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] exp_cnt();
    case (m_mode)
      M_ALARM: return 4'(m_e / (2 * HP));
      M_HOLD:  return 4'(NB);
      default: return 4'd0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_led", {7'd0, alarm_led}, {7'd0, exp_led()});
    chk("cmp_cnt", {4'd0, alarm_cnt}, {4'd0, exp_cnt()});
    chk("cmp_busy", {7'd0, busy}, {7'd0, m_mode != M_IDLE});
    chk("cmp_buzz", {7'd0, buzzer}, {7'd0, BUZZ & (m_mode == M_ALARM) & exp_led()});
  end

  // ---------------- driver tasks ----------------
  task automatic at(input int n);
    while (cyc - base < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    done = 1'b0;
    ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b1;
    base = cyc;
  endtask

  task automatic pin(input int n, input string name, input logic [7:0] exp, input int sel);
    at(n);
    @(negedge clk);
    case (sel)
      0:       chk(name, {7'd0, alarm_led}, exp);
      1:       chk(name, {4'd0, alarm_cnt}, exp);
      2:       chk(name, {7'd0, busy}, exp);
      default: chk(name, {7'd0, buzzer}, exp);
    endcase
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Burst, long HOLD, held ack, release in COOL
    do_reset();
    pin(2, "rst_led", 8'd0, 0);
    pin(2, "rst_busy", 8'd0, 2);
    at(10); done = 1'b1;
    pin(11, "s1_led_c11", 8'd1, 0);
    pin(11, "s1_busy_c11", 8'd1, 2);
    pin(11, "s1_buzz_c11", {7'd0, BUZZ}, 3);
    pin(14, "s1_led_c14", 8'd1, 0);
    pin(15, "s1_led_c15", 8'd0, 0);
    pin(19, "s1_led_c19", 8'd1, 0);
    pin(19, "s1_cnt_c19", 8'd1, 1);
    pin(27, "s1_cnt_c27", 8'd2, 1);
    pin(34, "s1_led_c34", 8'd0, 0);
    pin(35, "s1_led_c35", 8'd1, 0);
    pin(35, "s1_cnt_c35", 8'd3, 1);
    pin(35, "s1_buzz_c35", 8'd0, 3);
    pin(134, "s1_led_c134", 8'd1, 0);
    at(140); ack = 1'b1;
    pin(142, "s1_led_c142", 8'd1, 0);
    pin(143, "s1_led_c143", 8'd0, 0);
    pin(143, "s1_cnt_c143", 8'd0, 1);
    pin(143, "s1_busy_c143", 8'd1, 2);
    at(160); ack = 1'b0;
    at(170); done = 1'b0;
    pin(170, "s1_busy_c170", 8'd1, 2);
    pin(171, "s1_busy_c171", 8'd0, 2);

    // Mid-burst reset, done held through release, done glitch, rise in COOL
    rst = 1'b0; done = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b1;
    base = cyc;
    at(10); done = 1'b1;
    at(18); rst = 1'b0;
    #1;
    chk("s2_rst_busy", {7'd0, busy}, 8'd0);
    chk("s2_rst_led", {7'd0, alarm_led}, 8'd0);
    chk("s2_rst_cnt", {4'd0, alarm_cnt}, 8'd0);
    at(25); rst = 1'b1;
    pin(26, "s2_led_c26", 8'd1, 0);
    pin(26, "s2_busy_c26", 8'd1, 2);
    at(28); done = 1'b0;
    at(30); done = 1'b1;
    at(32); done = 1'b0;
    pin(34, "s2_cnt_c34", 8'd1, 1);
    at(40); ack = 1'b1;
    at(43); done = 1'b1;
    pin(43, "s2_led_c43", 8'd0, 0);
    at(46); ack = 1'b0;
    pin(47, "s2_busy_c47", 8'd1, 2);
    pin(47, "s2_led_c47", 8'd0, 0);
    at(50); done = 1'b0;
    pin(51, "s2_busy_c51", 8'd0, 2);

    // Held ack when rise arrives: rise wins, no further pulses
    do_reset();
    at(5); ack = 1'b1;
    at(7); done = 1'b1;
    pin(8, "s3_led_c8", 8'd1, 0);
    pin(20, "s3_busy_c20", 8'd1, 2);
    pin(32, "s3_led_c32", 8'd1, 0);
    pin(32, "s3_cnt_c32", 8'd3, 1);
    at(33); ack = 1'b0;
    at(35); ack = 1'b1;
    pin(37, "s3_led_c37", 8'd1, 0);
    pin(38, "s3_led_c38", 8'd0, 0);
    pin(38, "s3_cnt_c38", 8'd0, 1);
    ack = 1'b0;
    at(40); done = 1'b0;
    pin(41, "s3_busy_c41", 8'd0, 2);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_alarm.md
TIMER_ALARM -- requirements
Module: timer_alarm

Interface
REQ-001 Parameter HALF_PERIOD, default 4, number of clk cycles per alarm_led half-blink (range 1..255).
REQ-002 Parameter BLINKS, default 5, number of full on/off blinks per alarm burst (range 1..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 done  input  1  countdown-finished level from the upstream timer stage.
REQ-006 ack  input  1  raw user acknowledge button, asynchronous to clk.
REQ-007 alarm_led  output  1  blinking/steady alarm indicator.
REQ-008 buzzer  output  1  audible alarm drive.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 alarm_cnt  output  4  completed blinks in the current burst.

Function
REQ-011 The block SHALL register done into done_q each cycle; rise = done & ~done_q.
REQ-012 States SHALL be IDLE, ALARM, HOLD and COOL.
REQ-013 IDLE: on rise, the next state SHALL be ALARM, and alarm_led SHALL be 1 on that next cycle.
REQ-014 ALARM: alarm_led SHALL toggle every HALF_PERIOD cycles, starting high.
REQ-015 ALARM: alarm_cnt SHALL increment on each 0-to-1 edge that ends a full on/off period, saturating at BLINKS.
REQ-016 ALARM: after exactly 2*BLINKS*HALF_PERIOD cycles, the state SHALL go to HOLD with alarm_led=1.
REQ-017 HOLD: alarm_led SHALL stay at 1 until an acknowledge pulse.
REQ-018 ALARM or HOLD: an acknowledge pulse SHALL move the state to COOL on the next edge, with alarm_led=0 and alarm_cnt=0.
REQ-019 COOL: the state SHALL return to IDLE on the first cycle on which done is sampled 0; done rises SHALL be ignored in COOL.
REQ-020 done falling during ALARM or HOLD SHALL NOT cancel the alarm; only an acknowledge pulse or rst cancels it.
REQ-021 An acknowledge pulse in IDLE or COOL SHALL be ignored.
REQ-022 rise and an acknowledge pulse in the same IDLE cycle: rise SHALL win.
REQ-023 The acknowledge pulse SHALL be a one-cycle pulse generated 2 cycles after ack is first sampled high (2-flop synchronizer plus rising-edge detect).
REQ-024 A held ack SHALL yield only one pulse.
REQ-025 The phase counter SHALL be 8 bits and SHALL clear on every toggle and on every state entry.

Reset
REQ-026 Asserting rst SHALL force IDLE, alarm_led=0, buzzer=0, busy=0, alarm_cnt=0, done_q=0, cleared synchronizer flops and a cleared phase counter, at any time including mid-burst.
REQ-027 After rst deassertion, a done already high SHALL be treated as a rise on the first clock edge.

Configuration
REQ-028 With macro TIMER_ALARM_BUZZ_EN defined, buzzer SHALL equal alarm_led in ALARM and SHALL be 0 in all other states.
REQ-029 Without TIMER_ALARM_BUZZ_EN, buzzer SHALL be constant 0, the port SHALL remain present, and no extra logic SHALL be generated.

Structure
REQ-030 Package timer_alarm_pkg SHALL hold the state enum (2 bits), the PHASE_W=8 and CNT_W=4 constants, and the default HALF_PERIOD and BLINKS values.
REQ-031 Sub-module ack_sync SHALL implement the 2-flop synchronizer and rising-edge pulse; timer_alarm SHALL instantiate it once.

Verification (HALF_PERIOD=4, BLINKS=3)
REQ-032 done 0->1 at cycle 10 -> alarm_led=1 at cycle 11; toggles at 15, 19, 23, ...; busy=1 from cycle 11.
REQ-033 Full burst with no ack -> alarm_cnt reads 1, 2, 3, then HOLD at cycle 35 with alarm_led=1 held steady for 100 cycles.
REQ-034 ack high at cycle 40 for 20 cycles with done still 1 -> COOL at cycle 43, alarm_led=0, alarm_cnt=0, busy=1 and only one pulse; done->0 at cycle 70 -> IDLE at cycle 71 with busy=0.
REQ-035 rst low at cycle 18 mid-burst -> all outputs 0 immediately; done held 1 through the rst release at cycle 25 -> alarm restarts with alarm_led=1 at cycle 26.
REQ-036 done pulses 1 for 2 cycles during ALARM -> burst continues unaffected; a second done rise in COOL -> no new burst.
REQ-037 With TIMER_ALARM_BUZZ_EN, buzzer SHALL mirror alarm_led in the REQ-032 run and be 0 in HOLD; without it, buzzer SHALL be 0 throughout.
